m5_ddram_arbiter: RTL and testbench
===================================

Name: m5_ddram_arbiter

Overview:
- Shares the single MiSTer DDRAM port between three byte-wide requesters: the ioctl download loader (write), the CPU-side memory extension (EM-64/64KBF/BrnoMod, read/write) and the CAS tape player (read).
- Sequences every DDR3 command: issue, hold across BUSY, wait for read data, extract the byte lane.
- Keeps a one-line 64-bit read buffer for the tape player, because tape reads are sequential.
- Sits inside sordM5, between the loader/tape/memory logic and the top-level DDRAM_* pins.

Parameters:
- ADDR_W, 25, width of requester byte addresses.
- DDR_BASE, 29'h06000000, 64-bit-word base added to every DDRAM_ADDR.

Ports:
- clk_i  in  1  system clock; also driven out on DDRAM_CLK.
- reset_n_i  in  1  asynchronous, active-low reset.
- ld_req_i  in  1  loader write request, level.
- ld_addr_i  in  ADDR_W  loader byte address.
- ld_data_i  in  8  loader write data.
- ld_ack_o  out  1  loader done, one-cycle pulse.
- cpu_req_i  in  1  CPU request, level.
- cpu_we_i  in  1  1 = write, 0 = read.
- cpu_addr_i  in  ADDR_W  CPU byte address.
- cpu_data_i  in  8  CPU write data.
- cpu_data_o  out  8  CPU read data; held until the next CPU read completes.
- cpu_ack_o  out  1  CPU done, one-cycle pulse.
- tape_req_i  in  1  tape read request, level.
- tape_addr_i  in  ADDR_W  tape byte address.
- tape_data_o  out  8  tape read data; held until the next tape read completes.
- tape_ack_o  out  1  tape done, one-cycle pulse.
- tape_flush_i  in  1  invalidates the tape line buffer.
- DDRAM_CLK  out  1  equals clk_i.
- DDRAM_BUSY  in  1  DDR command not accepted.
- DDRAM_BURSTCNT  out  8  constant 1.
- DDRAM_ADDR  out  29  word address.
- DDRAM_DOUT  in  64  read data.
- DDRAM_DOUT_READY  in  1  read data valid.
- DDRAM_RD  out  1  read command.
- DDRAM_DIN  out  64  write data.
- DDRAM_BE  out  8  byte enables.
- DDRAM_WE  out  1  write command.

Behaviour:
- Reset values: all ack_o = 0; cpu_data_o, tape_data_o = 0; DDRAM_RD, DDRAM_WE = 0; DDRAM_ADDR, DDRAM_DIN, DDRAM_BE = 0; DDRAM_BURSTCNT = 1; tape buffer invalid; round-robin pointer = CPU first; FSM = IDLE.
- Handshake: requester holds req and operands stable until its ack pulse. If req is still high in the cycle after ack, that is a new transaction.
- FSM states: IDLE, WRITE, RD_CMD, RD_WAIT, DONE.
- IDLE arbitration, evaluated every cycle:
  - Loader has absolute priority.
  - CPU vs tape alternate by round-robin pointer when both are pending; the pointer toggles to the other requester on each grant to either.
  - On grant, latch requester id, address, data and we; go to WRITE or RD_CMD.
- Tape hit: tape request in IDLE with buffer valid and tag == tape_addr_i[ADDR_W-1:3]. Served with no DDR access: tape_data_o = buffered byte, tape_ack_o = 1 in the next cycle. This is lowest priority, so a loader or CPU grant in the same cycle wins.
- Command fields:
  - DDRAM_ADDR = DDR_BASE + addr[ADDR_W-1:3].
  - DDRAM_BE = 1 << addr[2:0].
  - DDRAM_DIN = data byte replicated ×8.
- WRITE: DDRAM_WE = 1 until a cycle with DDRAM_BUSY = 0 (accepted); then WE = 0, go to DONE.
- RD_CMD: DDRAM_RD = 1 until accepted; go to RD_WAIT. RD and WE are never high together.
- RD_WAIT: on DDRAM_DOUT_READY, select byte DOUT[8*addr[2:0] +: 8] into the granted requester's data_o.
  - Tape reads also load the full 64-bit word into the buffer, set the tag and set valid.
  - Go to DONE.
- DONE: pulse the granted ack for one cycle; return to IDLE.
- Latency with BUSY = 0:
  - Write: req sampled in cycle n → WE in cycle n+1 → ack in cycle n+2.
  - Read: ack in the cycle after DOUT_READY.
- Coherency: any loader or CPU write whose line matches the tape tag clears valid in the WRITE-accept cycle. tape_flush_i clears valid immediately and takes priority over a same-cycle fill.
- DOUT_READY outside RD_WAIT (stray data after reset mid-read) is ignored.
- Async reset mid-transaction aborts immediately to reset values; no ack is issued for the aborted request.
- Address wrap: word address addition is modulo 2^29.

Test Plan:
- Loader writes 0xA5 to 0x000005, BUSY = 0 → DDRAM_ADDR = 0x06000000, BE = 0x20, DIN = 0xA5A5A5A5A5A5A5A5, WE one cycle, ld_ack_o 2 cycles after req.
- CPU read 0x00000B with BUSY held 3 cycles, then DOUT = 0x1122334455667788 → RD held 4 cycles, cpu_data_o = 0x55, single ack.
- Tape reads 0x100..0x107 → one DDR read only; subsequent 7 acks each 1 cycle after req, returning the correct bytes.
- CPU and tape requesting continuously (tape misses) → grants alternate CPU, tape, CPU; loader req inserted mid-stream → granted next IDLE.
- Tape buffer holds line 0x20; CPU writes 0x104; next tape read at 0x100 → issues a DDR read. tape_flush_i has the same effect.
- reset_n_i low during RD_WAIT, then a stray DOUT_READY → outputs at reset values, no ack, FSM IDLE, next request served normally.

Source files
------------

// File: rtl/m5_ddram_arbiter.sv
// DDRAM port arbiter for sordM5: loader, CPU memory extension and tape player.
// The tape player gets a one-line 64-bit read buffer, since its reads are sequential.
module m5_ddram_arbiter #(
    parameter int          ADDR_W   = 25,
    parameter logic [28:0] DDR_BASE = 29'h06000000
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              ld_req_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [7:0]        ld_data_i,
    output logic              ld_ack_o,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [7:0]        cpu_data_i,
    output logic [7:0]        cpu_data_o,
    output logic              cpu_ack_o,
    input  logic              tape_req_i,
    input  logic [ADDR_W-1:0] tape_addr_i,
    output logic [7:0]        tape_data_o,
    output logic              tape_ack_o,
    input  logic              tape_flush_i,
    output logic              DDRAM_CLK,
    input  logic              DDRAM_BUSY,
    output logic [7:0]        DDRAM_BURSTCNT,
    output logic [28:0]       DDRAM_ADDR,
    input  logic [63:0]       DDRAM_DOUT,
    input  logic              DDRAM_DOUT_READY,
    output logic              DDRAM_RD,
    output logic [63:0]       DDRAM_DIN,
    output logic [7:0]        DDRAM_BE,
    output logic              DDRAM_WE
);

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_RD_CMD, S_RD_WAIT, S_DONE
    } state_t;

    typedef enum logic [1:0] {R_LD, R_CPU, R_TAPE} rid_t;

    localparam int TAG_W = ADDR_W - 3;

    state_t            state_q, state_d;
    rid_t              id_q, id_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rr_q, rr_d;
    logic              valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [63:0]       line_q, line_d;
    logic [7:0]        cpu_data_q, cpu_data_d;
    logic [7:0]        tape_data_q, tape_data_d;
    logic              ld_ack_q, ld_ack_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              tape_ack_q, tape_ack_d;
    logic              rd_q, rd_d;
    logic              we_q, we_d;
    logic [28:0]       ddr_addr_q, ddr_addr_d;
    logic [63:0]       din_q, din_d;
    logic [7:0]        be_q, be_d;

    logic              tape_pend, tape_hit, tape_miss;
    logic              grant, g_we;
    rid_t              g_id;
    logic [ADDR_W-1:0] g_addr;
    logic [7:0]        g_data;
    logic [7:0]        rd_byte;

    // A tape request seen while its hit-ack is showing is the old one.
    assign tape_pend = tape_req_i && !tape_ack_q;
    assign tape_hit  = tape_pend && valid_q && !tape_flush_i
                    && (tag_q == tape_addr_i[ADDR_W-1:3]);
    assign tape_miss = tape_pend && !tape_hit;
    assign rd_byte   = DDRAM_DOUT[{addr_q[2:0], 3'b000} +: 8];

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        addr_d      = addr_q;
        rr_d        = rr_q;
        valid_d     = valid_q;
        tag_d       = tag_q;
        line_d      = line_q;
        cpu_data_d  = cpu_data_q;
        tape_data_d = tape_data_q;
        ld_ack_d    = 1'b0;
        cpu_ack_d   = 1'b0;
        tape_ack_d  = 1'b0;
        rd_d        = rd_q;
        we_d        = we_q;
        ddr_addr_d  = ddr_addr_q;
        din_d       = din_q;
        be_d        = be_q;
        grant       = 1'b0;
        g_we        = cpu_we_i;
        g_id        = R_CPU;
        g_addr      = cpu_addr_i;
        g_data      = cpu_data_i;
        unique case (state_q)
            S_IDLE: begin
                if (ld_req_i) begin
                    grant  = 1'b1;
                    g_we   = 1'b1;
                    g_id   = R_LD;
                    g_addr = ld_addr_i;
                    g_data = ld_data_i;
                end else if (cpu_req_i && (!tape_miss || !rr_q)) begin
                    grant = 1'b1;
                    rr_d  = 1'b1;
                end else if (tape_miss) begin
                    grant  = 1'b1;
                    g_we   = 1'b0;
                    g_id   = R_TAPE;
                    g_addr = tape_addr_i;
                    rr_d   = 1'b0;
                end else if (tape_hit) begin
                    tape_ack_d  = 1'b1;
                    tape_data_d = line_q[{tape_addr_i[2:0], 3'b000} +: 8];
                end
                if (grant) begin
                    id_d       = g_id;
                    addr_d     = g_addr;
                    ddr_addr_d = DDR_BASE + 29'(g_addr[ADDR_W-1:3]);
                    be_d       = 8'b1 << g_addr[2:0];
                    din_d      = {8{g_data}};
                    we_d       = g_we;
                    rd_d       = !g_we;
                    state_d    = g_we ? S_WRITE : S_RD_CMD;
                end
            end
            S_WRITE: begin
                if (!DDRAM_BUSY) begin
                    we_d      = 1'b0;
                    ld_ack_d  = (id_q == R_LD);
                    cpu_ack_d = (id_q == R_CPU);
                    state_d   = S_DONE;
                    if (valid_q && tag_q == addr_q[ADDR_W-1:3]) begin
                        valid_d = 1'b0;
                    end
                end
            end
            S_RD_CMD: begin
                if (!DDRAM_BUSY) begin
                    rd_d    = 1'b0;
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (DDRAM_DOUT_READY) begin
                    state_d = S_DONE;
                    if (id_q == R_TAPE) begin
                        tape_data_d = rd_byte;
                        tape_ack_d  = 1'b1;
                        line_d      = DDRAM_DOUT;
                        tag_d       = addr_q[ADDR_W-1:3];
                        valid_d     = 1'b1;
                    end else begin
                        cpu_data_d = rd_byte;
                        cpu_ack_d  = 1'b1;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (tape_flush_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= S_IDLE;
            id_q        <= R_LD;
            addr_q      <= '0;
            rr_q        <= 1'b0;
            valid_q     <= 1'b0;
            tag_q       <= '0;
            line_q      <= '0;
            cpu_data_q  <= '0;
            tape_data_q <= '0;
            ld_ack_q    <= 1'b0;
            cpu_ack_q   <= 1'b0;
            tape_ack_q  <= 1'b0;
            rd_q        <= 1'b0;
            we_q        <= 1'b0;
            ddr_addr_q  <= '0;
            din_q       <= '0;
            be_q        <= '0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            rr_q        <= rr_d;
            valid_q     <= valid_d;
            tag_q       <= tag_d;
            line_q      <= line_d;
            cpu_data_q  <= cpu_data_d;
            tape_data_q <= tape_data_d;
            ld_ack_q    <= ld_ack_d;
            cpu_ack_q   <= cpu_ack_d;
            tape_ack_q  <= tape_ack_d;
            rd_q        <= rd_d;
            we_q        <= we_d;
            ddr_addr_q  <= ddr_addr_d;
            din_q       <= din_d;
            be_q        <= be_d;
        end
    end

    assign ld_ack_o       = ld_ack_q;
    assign cpu_ack_o      = cpu_ack_q;
    assign tape_ack_o     = tape_ack_q;
    assign cpu_data_o     = cpu_data_q;
    assign tape_data_o    = tape_data_q;
    assign DDRAM_CLK      = clk_i;
    assign DDRAM_BURSTCNT = 8'd1;
    assign DDRAM_ADDR     = ddr_addr_q;
    assign DDRAM_RD       = rd_q;
    assign DDRAM_WE       = we_q;
    assign DDRAM_DIN      = din_q;
    assign DDRAM_BE       = be_q;

endmodule

// File: tb/tb_m5_ddram_arbiter.sv
// Bench for m5_ddram_arbiter: DDR slave model, byte-level reference memory
// and directed requester sequences.
module tb_m5_ddram_arbiter;

    localparam int          AW   = 25;
    localparam logic [28:0] BASE = 29'h06000000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          ld_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
    logic          tape_req = 1'b0, tape_flush = 1'b0;
    logic [AW-1:0] ld_addr = '0, cpu_addr = '0, tape_addr = '0;
    logic [7:0]    ld_data = '0, cpu_wdata = '0;
    logic [7:0]    cpu_rdata, tape_data;
    logic          ld_ack, cpu_ack, tape_ack;
    logic          ddr_clk, ddr_busy = 1'b0, ddr_rdy = 1'b0, ddr_rd, ddr_we;
    logic [7:0]    ddr_burst, ddr_be;
    logic [28:0]   ddr_addr;
    logic [63:0]   ddr_dout = '0, ddr_din;

    always #5 clk = ~clk;

    m5_ddram_arbiter #(.ADDR_W(AW), .DDR_BASE(BASE)) dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .ld_req_i(ld_req), .ld_addr_i(ld_addr), .ld_data_i(ld_data),
        .ld_ack_o(ld_ack),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
        .cpu_data_i(cpu_wdata), .cpu_data_o(cpu_rdata), .cpu_ack_o(cpu_ack),
        .tape_req_i(tape_req), .tape_addr_i(tape_addr),
        .tape_data_o(tape_data), .tape_ack_o(tape_ack),
        .tape_flush_i(tape_flush),
        .DDRAM_CLK(ddr_clk), .DDRAM_BUSY(ddr_busy),
        .DDRAM_BURSTCNT(ddr_burst), .DDRAM_ADDR(ddr_addr),
        .DDRAM_DOUT(ddr_dout), .DDRAM_DOUT_READY(ddr_rdy),
        .DDRAM_RD(ddr_rd), .DDRAM_DIN(ddr_din), .DDRAM_BE(ddr_be),
        .DDRAM_WE(ddr_we)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference: flat byte memory; DDR slave: 64-bit word memory.
    logic [7:0]  ref_mem [int];
    logic [63:0] ddr_mem [logic [28:0]];

    function automatic logic [7:0] init_byte(input int a);
        return 8'((a * 7 + 3) & 255);
    endfunction

    function automatic logic [7:0] ref_byte(input int a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_byte(a);
    endfunction

    function automatic logic [63:0] slave_word(input logic [28:0] w);
        logic [63:0] v;
        if (ddr_mem.exists(w)) return ddr_mem[w];
        for (int b = 0; b < 8; b++) v[8*b +: 8] = init_byte(int'(w - BASE) * 8 + b);
        return v;
    endfunction

    function automatic logic [7:0] slave_byte(input int a);
        logic [63:0] v;
        v = slave_word(BASE + 29'(a >> 3));
        return v[8*(a & 7) +: 8];
    endfunction

    task automatic preload(input int idx, input logic [63:0] val);
        ddr_mem[BASE + 29'(idx)] = val;
        for (int b = 0; b < 8; b++) ref_mem[idx*8 + b] = val[8*b +: 8];
    endtask

    int          busy_cfg = 0, rd_lat = 1, busy_left = 0, rd_delay = 0;
    int          rd_count = 0;
    bit          rd_pending = 0;
    logic [63:0] rd_word;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            ddr_rdy = 1'b0;
            if (rd_pending) begin
                if (rd_delay == 0) begin
                    ddr_rdy = 1'b1;
                    ddr_dout = rd_word;
                    rd_pending = 0;
                end else rd_delay--;
            end
            if (ddr_rd || ddr_we) begin
                if (busy_left > 0) begin
                    ddr_busy = 1'b1;
                    busy_left--;
                end else begin
                    ddr_busy = 1'b0;
                    busy_left = busy_cfg;
                    if (ddr_we) begin
                        logic [63:0] w;
                        chk("din_repl", ddr_din, {8{ddr_din[7:0]}});
                        chk("be_onehot", 64'($onehot(ddr_be)), 1);
                        w = slave_word(ddr_addr);
                        for (int b = 0; b < 8; b++)
                            if (ddr_be[b]) w[8*b +: 8] = ddr_din[8*b +: 8];
                        ddr_mem[ddr_addr] = w;
                    end else begin
                        rd_count++;
                        rd_pending = 1;
                        rd_delay = rd_lat;
                        rd_word = slave_word(ddr_addr);
                    end
                end
            end else begin
                ddr_busy = 1'b0;
                busy_left = busy_cfg;
            end
        end
    end

    int ack_log[$];

    always @(posedge clk) begin
        #1;
        if (ddr_rd || ddr_we) chk("rd_we_excl", 64'(ddr_rd & ddr_we), 0);
        if (ld_ack) begin
            ack_log.push_back(1);
            chk("ld_ack_req", 64'(ld_req), 1);
            ref_mem[int'(ld_addr)] = ld_data;
            chk("ld_mem", slave_byte(int'(ld_addr)), ld_data);
        end
        if (cpu_ack) begin
            ack_log.push_back(2);
            chk("cpu_ack_req", 64'(cpu_req), 1);
            if (cpu_we) begin
                ref_mem[int'(cpu_addr)] = cpu_wdata;
                chk("cpu_mem", slave_byte(int'(cpu_addr)), cpu_wdata);
            end else begin
                chk("cpu_rdata", cpu_rdata, ref_byte(int'(cpu_addr)));
            end
        end
        if (tape_ack) begin
            ack_log.push_back(3);
            chk("tape_ack_req", 64'(tape_req), 1);
            chk("tape_data", tape_data, ref_byte(int'(tape_addr)));
        end
    end

    task automatic do_ld(input logic [AW-1:0] a, input logic [7:0] d,
                         output int lat);
        bit got = 0;
        ld_addr = a; ld_data = d; ld_req = 1'b1; lat = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            lat++;
            if (ld_ack) begin got = 1; break; end
        end
        if (!got) chk("ld_timeout", 0, 1);
        ld_req = 1'b0;
    endtask

    task automatic do_cpu(input logic we, input logic [AW-1:0] a,
                          input logic [7:0] d, output int lat);
        bit got = 0;
        cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1; lat = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            lat++;
            if (cpu_ack) begin got = 1; break; end
        end
        if (!got) chk("cpu_timeout", 0, 1);
        cpu_req = 1'b0;
    endtask

    task automatic do_tape(input logic [AW-1:0] a, output int lat);
        bit got = 0;
        tape_addr = a; tape_req = 1'b1; lat = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            lat++;
            if (tape_ack) begin got = 1; break; end
        end
        if (!got) chk("tape_timeout", 0, 1);
        tape_req = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_acks"}, {61'b0, ld_ack, cpu_ack, tape_ack}, 0);
        chk({tag, "_cpu_data"}, cpu_rdata, 0);
        chk({tag, "_tape_data"}, tape_data, 0);
        chk({tag, "_rdwe"}, {62'b0, ddr_rd, ddr_we}, 0);
        chk({tag, "_addr"}, ddr_addr, 0);
        chk({tag, "_din"}, ddr_din, 0);
        chk({tag, "_be"}, ddr_be, 0);
        chk({tag, "_burst"}, ddr_burst, 1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, r0, rd_cyc, acks;
        bit prev_rdy, got, stray;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Loader write, no BUSY.
        ld_addr = 25'h000005; ld_data = 8'hA5; ld_req = 1'b1;
        @(negedge clk);
        chk("t1_we", 64'(ddr_we), 1);
        chk("t1_rd", 64'(ddr_rd), 0);
        chk("t1_addr", ddr_addr, 29'h06000000);
        chk("t1_be", ddr_be, 8'h20);
        chk("t1_din", ddr_din, 64'hA5A5A5A5A5A5A5A5);
        chk("t1_early_ack", 64'(ld_ack), 0);
        @(negedge clk);
        chk("t1_we_off", 64'(ddr_we), 0);
        chk("t1_ack", 64'(ld_ack), 1);
        ld_req = 1'b0;
        @(negedge clk);
        chk("t1_ack_pulse", 64'(ld_ack), 0);

        // CPU read with BUSY held three cycles.
        preload(1, 64'h1122334455667788);
        busy_cfg = 3; rd_lat = 2;
        @(negedge clk);
        cpu_we = 1'b0; cpu_addr = 25'h00000B; cpu_req = 1'b1;
        rd_cyc = 0; prev_rdy = 0; got = 0; acks = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            rd_cyc += int'(ddr_rd);
            acks += int'(cpu_ack);
            if (prev_rdy) begin
                chk("t2_ack_after_rdy", 64'(cpu_ack), 1);
                got = 1;
                break;
            end
            prev_rdy = ddr_rdy;
        end
        chk("t2_done", 64'(got), 1);
        chk("t2_rd_cycles", 64'(rd_cyc), 4);
        chk("t2_acks", 64'(acks), 1);
        chk("t2_data", cpu_rdata, 8'h55);
        cpu_req = 1'b0;
        busy_cfg = 0; rd_lat = 1;
        @(negedge clk);
        chk("t2_ack_pulse", 64'(cpu_ack), 0);
        chk("t2_data_held", cpu_rdata, 8'h55);

        // Tape line 0x100..0x107: one DDR read, then buffer hits.
        r0 = rd_count;
        do_tape(25'h100, lat);
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            do_tape(25'(32'h100 + i), lat);
            chk("t3_hit_lat", 64'(lat), 1);
        end
        chk("t3_line_reads", 64'(rd_count - r0), 1);

        // Coherency: CPU write into buffered line, then flush.
        @(negedge clk);
        r0 = rd_count;
        do_tape(25'h103, lat);
        chk("t5_prehit", 64'(rd_count - r0), 0);
        do_cpu(1'b1, 25'h104, 8'h5A, lat);
        @(negedge clk);
        r0 = rd_count;
        do_tape(25'h100, lat);
        chk("t5_write_inval", 64'(rd_count - r0), 1);
        @(negedge clk);
        r0 = rd_count;
        do_tape(25'h104, lat);
        chk("t5_rehit", 64'(rd_count - r0), 0);
        tape_flush = 1'b1;
        @(negedge clk);
        tape_flush = 1'b0;
        r0 = rd_count;
        do_tape(25'h101, lat);
        chk("t5_flush_inval", 64'(rd_count - r0), 1);

        // CPU and tape streaming, loader injected after two grants.
        @(negedge clk);
        ack_log.delete();
        fork
            begin
                int l;
                for (int i = 0; i < 3; i++) do_cpu(1'b0, 25'(32'h300 + 8*i), 8'h00, l);
            end
            begin
                int l;
                for (int i = 0; i < 3; i++) do_tape(25'(32'h200 + 8*i), l);
            end
            begin
                int l;
                for (int i = 0; i < 300; i++) begin
                    @(negedge clk);
                    if (ack_log.size() >= 2) break;
                end
                do_ld(25'h400, 8'h3C, l);
            end
        join
        begin
            int exp_order[7] = '{2, 3, 1, 2, 3, 2, 3};
            chk("t4_grants", 64'(ack_log.size()), 7);
            for (int i = 0; i < 7 && i < ack_log.size(); i++)
                chk($sformatf("t4_grant%0d", i), 64'(ack_log[i]), 64'(exp_order[i]));
        end

        // Reset during RD_WAIT, then stray DOUT_READY.
        rd_lat = 8;
        @(negedge clk);
        r0 = rd_count;
        cpu_we = 1'b0; cpu_addr = 25'h500; cpu_req = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rd_count != r0) break;
        end
        chk("t6_rd_issued", 64'(rd_count - r0), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        cpu_req = 1'b0;
        #1;
        check_reset_vals("t6_async");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stray = 0; acks = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            stray |= ddr_rdy;
            acks += int'(ld_ack) + int'(cpu_ack) + int'(tape_ack);
        end
        chk("t6_stray_seen", 64'(stray), 1);
        chk("t6_no_ack", 64'(acks), 0);
        chk("t6_cpu_data", cpu_rdata, 0);
        chk("t6_rdwe_idle", {62'b0, ddr_rd, ddr_we}, 0);
        rd_lat = 1;
        do_cpu(1'b0, 25'h00000B, 8'h00, lat);
        chk("t6_after_data", cpu_rdata, 8'h55);
        @(negedge clk);
        r0 = rd_count;
        do_tape(25'h102, lat);
        chk("t6_buf_invalid", 64'(rd_count - r0), 1);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
